// File: rtl/x2050gctr.sv
// x2050gctr: multi-field G (length) counter with chained borrow ripple.
//
// Holds NFIELD counter fields of FW bits each (field 0 least significant).
// Each field can be loaded from W, decremented on its own, or decremented
// as part of a chained multi-field counter. Each field also has a sign
// (underflow-on-last-update) flag and a sticky underflow flag. State only
// changes on a ROS advance. I/O mode freezes the flags but not the counters.
//
// Ports:
//   i_clk          clock
//   i_reset_n      synchronous active-low reset
//   i_ros_advance  qualifies every state change
//   i_io_mode      blocks sign/sticky flag updates
//   i_set_mask     per field: load from i_w_reg (wins over decrement)
//   i_dec_mask     per field: decrement request
//   i_chain        per field: decrement only on borrow from field k-1 (bit 0 ignored)
//   i_w_reg        load data, field k in bits [k*FW +: FW]
//   o_g_reg        counter fields, packed like i_w_reg
//   o_sign         per-field underflow flag from the last update
//   o_uflow        sticky underflow, cleared by load or reset
//   o_zero         per-field zero detect
//   o_all_zero     all fields zero
module x2050gctr #(
    parameter int unsigned NFIELD = 2,
    parameter int unsigned FW     = 4,
    parameter int unsigned SAT    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ros_advance,
    input  logic                 i_io_mode,
    input  logic [NFIELD-1:0]    i_set_mask,
    input  logic [NFIELD-1:0]    i_dec_mask,
    input  logic [NFIELD-1:0]    i_chain,
    input  logic [NFIELD*FW-1:0] i_w_reg,
    output logic [NFIELD*FW-1:0] o_g_reg,
    output logic [NFIELD-1:0]    o_sign,
    output logic [NFIELD-1:0]    o_uflow,
    output logic [NFIELD-1:0]    o_zero,
    output logic                 o_all_zero
);

    logic [NFIELD*FW-1:0] g_q, g_d;
    logic [NFIELD-1:0]    sign_q, sign_d;
    logic [NFIELD-1:0]    uflow_q, uflow_d;
    logic [NFIELD-1:0]    field_zero;
    logic [NFIELD-1:0]    dec_en;
    logic [NFIELD-1:0]    borrow;

    // Zero detect per field on registered state.
    always_comb begin
        field_zero = '0;
        for (int k = 0; k < NFIELD; k++) begin
            field_zero[k] = (g_q[k*FW +: FW] == '0);
        end
    end

    // Borrow ripple from field 0 upward. prev_b carries b[k-1] so the chain
    // stays a single combinational pass with no self-referencing vector.
    always_comb begin
        logic prev_b;
        logic chain_ok;
        dec_en = '0;
        borrow = '0;
        prev_b = 1'b0;
        for (int k = 0; k < NFIELD; k++) begin
            chain_ok  = (k == 0) || !i_chain[k] || prev_b;
            dec_en[k] = i_dec_mask[k] && !i_set_mask[k] && chain_ok;
            borrow[k] = dec_en[k] && field_zero[k];
            prev_b    = borrow[k];
        end
    end

    // Next-state for counters and flags.
    always_comb begin
        g_d     = g_q;
        sign_d  = sign_q;
        uflow_d = uflow_q;
        if (i_ros_advance) begin
            for (int k = 0; k < NFIELD; k++) begin
                if (i_set_mask[k]) begin
                    g_d[k*FW +: FW] = i_w_reg[k*FW +: FW];
                end else if (dec_en[k]) begin
                    if ((SAT != 0) && field_zero[k]) begin
                        g_d[k*FW +: FW] = '0;
                    end else begin
                        g_d[k*FW +: FW] = g_q[k*FW +: FW] - 1'b1;
                    end
                end

                if (!i_io_mode) begin
                    if (i_set_mask[k]) begin
                        sign_d[k]  = 1'b0;
                        uflow_d[k] = 1'b0;
                    end else if (dec_en[k]) begin
                        sign_d[k]  = borrow[k];
                        uflow_d[k] = uflow_q[k] | borrow[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            g_q     <= '0;
            sign_q  <= '0;
            uflow_q <= '0;
        end else begin
            g_q     <= g_d;
            sign_q  <= sign_d;
            uflow_q <= uflow_d;
        end
    end

    assign o_g_reg    = g_q;
    assign o_sign     = sign_q;
    assign o_uflow    = uflow_q;
    assign o_zero     = field_zero;
    assign o_all_zero = &field_zero;

endmodule
